// File: rtl/forwarding_scoreboard_if.sv
// Issue-slot, bypass-stage and result bundle for forwarding_scoreboard.
// master drives issue/stage/flush; slave (the scoreboard) returns operands, stall and stats.
interface forwarding_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NPORT  = 2,
  parameter int NSTAGE = 3,
  parameter int LAT_W  = 3
);
  localparam int RW = $clog2(NREG);

  logic                     flush;
  logic                     iss_valid;
  logic                     iss_wen;
  logic [RW-1:0]            iss_rd;
  logic [LAT_W-1:0]         iss_lat;
  logic [NPORT*RW-1:0]      iss_rs;
  logic [NPORT-1:0]         iss_ruse;
  logic [NSTAGE-1:0]        stg_wen;
  logic [NSTAGE*RW-1:0]     stg_rd;
  logic [NSTAGE-1:0]        stg_dvalid;
  logic [NSTAGE*DATA_W-1:0] stg_data;
  logic [NPORT-1:0]         opd_fwd;
  logic [NPORT*DATA_W-1:0]  opd_data;
  logic                     stall;
  logic [31:0]              stat_stall_cyc;
  logic [31:0]              stat_fwd_hits;

  modport master (
    output flush, iss_valid, iss_wen, iss_rd, iss_lat, iss_rs, iss_ruse,
    output stg_wen, stg_rd, stg_dvalid, stg_data,
    input  opd_fwd, opd_data, stall, stat_stall_cyc, stat_fwd_hits
  );

  modport slave (
    input  flush, iss_valid, iss_wen, iss_rd, iss_lat, iss_rs, iss_ruse,
    input  stg_wen, stg_rd, stg_dvalid, stg_data,
    output opd_fwd, opd_data, stall, stat_stall_cyc, stat_fwd_hits
  );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Operand forwarding / hazard unit with a per-register long-latency countdown scoreboard.
// FWD_STATS_EN enables saturating stall-cycle and forwarded-operand counters.
module forwarding_scoreboard #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NPORT  = 2,
  parameter int NSTAGE = 3,
  parameter int LAT_W  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  forwarding_scoreboard_if.slave bus
);
  localparam int RW = $clog2(NREG);

  logic [LAT_W-1:0]        cnt_r [NREG];
  logic [NPORT-1:0]        fwd_s;
  logic [NPORT*DATA_W-1:0] data_s;
  logic                    raw_s;
  logic                    waw_s;
  logic                    stall_s;
  logic                    accept_s;

  // Resolve each active source port: scoreboard RAW, then youngest matching bypass stage
  always_comb begin
    logic [RW-1:0] rs_v;
    logic          hit_v;
    fwd_s  = '0;
    data_s = '0;
    raw_s  = 1'b0;
    rs_v   = '0;
    hit_v  = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      rs_v  = bus.iss_rs[p*RW +: RW];
      hit_v = 1'b0;
      if (bus.iss_valid && bus.iss_ruse[p] && (rs_v != '0)) begin
        if (cnt_r[rs_v] != '0) begin
          raw_s = 1'b1;
        end else begin
          raw_s = raw_s;
        end
        for (int s = 0; s < NSTAGE; s++) begin
          if (!hit_v && bus.stg_wen[s] && (bus.stg_rd[s*RW +: RW] == rs_v)) begin
            hit_v = 1'b1;
            if (bus.stg_dvalid[s]) begin
              fwd_s[p]                    = 1'b1;
              data_s[p*DATA_W +: DATA_W]  = bus.stg_data[s*DATA_W +: DATA_W];
            end else begin
              raw_s = 1'b1;
            end
          end else begin
            hit_v = hit_v;
          end
        end
      end else begin
        fwd_s[p] = 1'b0;
      end
    end
  end

  // WAW only blocks when the in-flight producer would finish after the new one
  always_comb begin
    waw_s    = bus.iss_valid && bus.iss_wen && (bus.iss_rd != '0) &&
               (cnt_r[bus.iss_rd] > bus.iss_lat);
    stall_s  = raw_s | waw_s;
    accept_s = bus.iss_valid & ~stall_s;
  end

  // Outputs are forced quiet while reset is held
  always_comb begin
    if (RST) begin
      bus.opd_fwd  = '0;
      bus.opd_data = '0;
      bus.stall    = 1'b0;
    end else begin
      bus.opd_fwd  = fwd_s;
      bus.opd_data = data_s;
      bus.stall    = stall_s;
    end
  end

  // Countdown scoreboard: flush beats a new issue, a new issue beats the decrement
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= '0;
      end
    end else begin
      cnt_r[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (bus.flush) begin
          cnt_r[r] <= '0;
        end else if (accept_s && bus.iss_wen && (bus.iss_rd == RW'(r)) && (bus.iss_lat != '0)) begin
          cnt_r[r] <= bus.iss_lat;
        end else if (cnt_r[r] != '0) begin
          cnt_r[r] <= cnt_r[r] - LAT_W'(1'b1);
        end else begin
          cnt_r[r] <= cnt_r[r];
        end
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] stall_cyc_r;
  logic [31:0] fwd_hits_r;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[32]) begin
      sat_add = {32{1'b1}};
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

  function automatic logic [31:0] ones_count(input logic [NPORT-1:0] v);
    ones_count = 32'd0;
    for (int i = 0; i < NPORT; i++) begin
      ones_count = ones_count + {31'd0, v[i]};
    end
  endfunction

  // Saturating statistics; only RST clears them, flush leaves them alone
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cyc_r <= 32'd0;
      fwd_hits_r  <= 32'd0;
    end else begin
      stall_cyc_r <= sat_add(stall_cyc_r, {31'd0, stall_s});
      fwd_hits_r  <= sat_add(fwd_hits_r, accept_s ? ones_count(fwd_s) : 32'd0);
    end
  end

  assign bus.stat_stall_cyc = stall_cyc_r;
  assign bus.stat_fwd_hits  = fwd_hits_r;
`else
  assign bus.stat_stall_cyc = 32'd0;
  assign bus.stat_fwd_hits  = 32'd0;
`endif
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Scoreboard-style bench for forwarding_scoreboard: expectations queued at drive, checked at negedge.
`timescale 1ns/1ps
module tb_forwarding_scoreboard;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int NPORT  = 2;
  localparam int NSTAGE = 3;
  localparam int LAT_W  = 3;
  localparam int RW     = 5;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  forwarding_scoreboard_if #(.DATA_W(DATA_W), .NREG(NREG), .NPORT(NPORT),
                             .NSTAGE(NSTAGE), .LAT_W(LAT_W)) bus ();

  forwarding_scoreboard #(.DATA_W(DATA_W), .NREG(NREG), .NPORT(NPORT),
                          .NSTAGE(NSTAGE), .LAT_W(LAT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [1:0]  fwd;
    logic [63:0] data;
    logic        stall;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned mdl_stall = 0;
  int unsigned mdl_fwd   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    bus.flush      = 1'b0;
    bus.iss_valid  = 1'b0;
    bus.iss_wen    = 1'b0;
    bus.iss_rd     = '0;
    bus.iss_lat    = '0;
    bus.iss_rs     = '0;
    bus.iss_ruse   = '0;
    bus.stg_wen    = '0;
    bus.stg_rd     = '0;
    bus.stg_dvalid = '0;
    bus.stg_data   = '0;
  endtask

  task automatic set_stg(input int s, input logic [4:0] rd, input logic dv, input logic [31:0] d);
    bus.stg_wen[s]                  = 1'b1;
    bus.stg_rd[s*RW +: RW]          = rd;
    bus.stg_dvalid[s]               = dv;
    bus.stg_data[s*DATA_W +: DATA_W] = d;
  endtask

  task automatic issue(input logic wen, input logic [4:0] rd, input logic [2:0] lat,
                       input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] ruse);
    bus.iss_valid = 1'b1;
    bus.iss_wen   = wen;
    bus.iss_rd    = rd;
    bus.iss_lat   = lat;
    bus.iss_rs    = {rs1, rs0};
    bus.iss_ruse  = ruse;
  endtask

  task automatic step(input string tag, input logic [1:0] efwd, input logic [63:0] edata,
                      input logic estall);
    exp_t e;
    logic [31:0] exp_sc;
    logic [31:0] exp_fh;
    e.tag = tag; e.fwd = efwd; e.data = edata; e.stall = estall;
    exp_q.push_back(e);
    if (RST) begin
      mdl_stall = 0;
      mdl_fwd   = 0;
    end
    @(negedge CLK);
    e = exp_q.pop_front();
`ifdef FWD_STATS_EN
    exp_sc = mdl_stall;
    exp_fh = mdl_fwd;
`else
    exp_sc = 32'd0;
    exp_fh = 32'd0;
`endif
    check_eq({e.tag, ".fwd"},   {62'd0, bus.opd_fwd}, {62'd0, e.fwd});
    check_eq({e.tag, ".data"},  bus.opd_data, e.data);
    check_eq({e.tag, ".stall"}, {63'd0, bus.stall}, {63'd0, e.stall});
    check_eq({e.tag, ".stat_stall"}, {32'd0, bus.stat_stall_cyc}, {32'd0, exp_sc});
    check_eq({e.tag, ".stat_fwd"},   {32'd0, bus.stat_fwd_hits},  {32'd0, exp_fh});
    if (!RST) begin
      if (e.stall) mdl_stall++;
      if (bus.iss_valid && !e.stall) mdl_fwd += $countones(e.fwd);
    end
    @(posedge CLK);
    #1;
    idle();
  endtask

  initial begin
    RST = 1'b1;
    idle();
    // outputs quiet under reset even with forwarding / load-use stimulus
    set_stg(0, 5'd3, 1'b1, 32'hAAAA); issue(1'b0, 5'd0, 3'd0, 5'd3, 5'd0, 2'b01);
    step("rst_fwd", 2'b00, 64'h0, 1'b0);
    set_stg(0, 5'd4, 1'b0, 32'h0); issue(1'b0, 5'd0, 3'd0, 5'd0, 5'd4, 2'b10);
    step("rst_ld", 2'b00, 64'h0, 1'b0);
    RST = 1'b0;

    // youngest stage wins
    set_stg(0, 5'd3, 1'b1, 32'hAAAA); set_stg(1, 5'd3, 1'b1, 32'hBBBB);
    issue(1'b0, 5'd0, 3'd0, 5'd3, 5'd0, 2'b01);
    step("ex_prio", 2'b01, 64'h0000_0000_0000_AAAA, 1'b0);

    // load-use, and the same with the port unused
    set_stg(0, 5'd4, 1'b0, 32'h0); issue(1'b0, 5'd0, 3'd0, 5'd0, 5'd4, 2'b10);
    step("load_use", 2'b00, 64'h0, 1'b1);
    set_stg(0, 5'd4, 1'b0, 32'h0); issue(1'b0, 5'd0, 3'd0, 5'd0, 5'd4, 2'b00);
    step("load_unused", 2'b00, 64'h0, 1'b0);

    // long-latency producer r5, lat 3
    issue(1'b1, 5'd5, 3'd3, 5'd0, 5'd0, 2'b00);
    step("r5_issue", 2'b00, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 5'd0, 3'd0, 5'd5, 5'd0, 2'b01);
      step("r5_raw", 2'b00, 64'h0, 1'b1);
    end
    set_stg(2, 5'd5, 1'b1, 32'h1234); issue(1'b0, 5'd0, 3'd0, 5'd5, 5'd0, 2'b01);
    step("r5_done", 2'b01, 64'h0000_0000_0000_1234, 1'b0);

    // WAW on r6
    issue(1'b1, 5'd6, 3'd4, 5'd0, 5'd0, 2'b00);
    step("waw_first", 2'b00, 64'h0, 1'b0);
    issue(1'b1, 5'd6, 3'd1, 5'd0, 5'd0, 2'b00);
    step("waw_stall", 2'b00, 64'h0, 1'b1);
    issue(1'b1, 5'd6, 3'd4, 5'd0, 5'd0, 2'b00);
    step("waw_ok", 2'b00, 64'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 5'd0, 3'd0, 5'd6, 5'd0, 2'b01);
      step("r6_raw", 2'b00, 64'h0, 1'b1);
    end
    set_stg(1, 5'd6, 1'b1, 32'h6666); issue(1'b0, 5'd0, 3'd0, 5'd6, 5'd0, 2'b01);
    step("r6_done", 2'b01, 64'h0000_0000_0000_6666, 1'b0);

    // register 0 never stalls or forwards
    set_stg(0, 5'd0, 1'b0, 32'h1); set_stg(1, 5'd0, 1'b0, 32'h2); set_stg(2, 5'd0, 1'b0, 32'h3);
    issue(1'b1, 5'd0, 3'd5, 5'd0, 5'd0, 2'b11);
    step("r0_all", 2'b00, 64'h0, 1'b0);
    issue(1'b0, 5'd0, 3'd0, 5'd0, 5'd0, 2'b11);
    step("r0_next", 2'b00, 64'h0, 1'b0);

    // flush clears a countdown; flush also beats a simultaneous issue
    issue(1'b1, 5'd7, 3'd5, 5'd0, 5'd0, 2'b00);
    step("r7_issue", 2'b00, 64'h0, 1'b0);
    issue(1'b0, 5'd0, 3'd0, 5'd7, 5'd0, 2'b01); bus.flush = 1'b1;
    step("r7_flush", 2'b00, 64'h0, 1'b1);
    issue(1'b0, 5'd0, 3'd0, 5'd7, 5'd0, 2'b01);
    step("r7_after", 2'b00, 64'h0, 1'b0);
    issue(1'b1, 5'd8, 3'd3, 5'd0, 5'd0, 2'b00); bus.flush = 1'b1;
    step("flush_iss", 2'b00, 64'h0, 1'b0);
    issue(1'b0, 5'd0, 3'd0, 5'd8, 5'd0, 2'b01);
    step("r8_after", 2'b00, 64'h0, 1'b0);

    // youngest load shadows an older valid result
    set_stg(0, 5'd9, 1'b0, 32'h0); set_stg(2, 5'd9, 1'b1, 32'h99);
    issue(1'b0, 5'd0, 3'd0, 5'd9, 5'd0, 2'b01);
    step("young_load", 2'b00, 64'h0, 1'b1);
    set_stg(1, 5'd9, 1'b1, 32'h11); set_stg(2, 5'd9, 1'b1, 32'h22);
    issue(1'b0, 5'd0, 3'd0, 5'd0, 5'd9, 2'b10);
    step("mem_prio", 2'b10, 64'h0000_0011_0000_0000, 1'b0);
    set_stg(0, 5'd10, 1'b1, 32'h1010); set_stg(2, 5'd11, 1'b1, 32'h1111);
    issue(1'b0, 5'd0, 3'd0, 5'd10, 5'd11, 2'b11);
    step("dual_fwd", 2'b11, 64'h0000_1111_0000_1010, 1'b0);
    // forwarded data stays valid while the other port stalls
    set_stg(0, 5'd12, 1'b1, 32'h12); set_stg(1, 5'd13, 1'b0, 32'h0);
    issue(1'b0, 5'd0, 3'd0, 5'd12, 5'd13, 2'b11);
    step("fwd_in_stall", 2'b01, 64'h0000_0000_0000_0012, 1'b1);

    // reset mid-countdown discards the entry
    issue(1'b1, 5'd14, 3'd6, 5'd0, 5'd0, 2'b00);
    step("r14_issue", 2'b00, 64'h0, 1'b0);
    RST = 1'b1;
    set_stg(0, 5'd15, 1'b1, 32'h5); issue(1'b0, 5'd0, 3'd0, 5'd14, 5'd15, 2'b11);
    step("rst_mid", 2'b00, 64'h0, 1'b0);
    RST = 1'b0;
    issue(1'b0, 5'd0, 3'd0, 5'd14, 5'd0, 2'b01);
    step("r14_after", 2'b00, 64'h0, 1'b0);
    step("final_idle", 2'b00, 64'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
